// File: rtl/pwm_deadtime_if.sv
// Control and gate-drive signals of the PWM dead-time output stage.
// The master drives the PWM line and the configuration inputs. The slave (the stage itself) drives the gate outputs.
interface pwm_deadtime_if #(
   parameter int unsigned DT_W = 8
);
   logic            en;
   logic            pwm_in;
   logic [DT_W-1:0] dead_rise;
   logic [DT_W-1:0] dead_fall;
   logic            fault;
   logic            fault_clr;
   logic            out_h;
   logic            out_l;
   logic            dt_active;
   logic            fault_flag;

   modport master (
      output en, pwm_in, dead_rise, dead_fall, fault, fault_clr,
      input  out_h, out_l, dt_active, fault_flag
   );

   modport slave (
      input  en, pwm_in, dead_rise, dead_fall, fault, fault_clr,
      output out_h, out_l, dt_active, fault_flag
   );
endinterface

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive stage with programmable rise/fall dead times,
// short-pulse swallowing and a latched fault shutdown.
module pwm_deadtime #(
   parameter int unsigned DT_W = 8
) (
   input logic           clk,
   input logic           rst_n,
   pwm_deadtime_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DT_H  = 3'd1,
      S_HIGH  = 3'd2,
      S_DT_L  = 3'd3,
      S_LOW   = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [DT_W-1:0] cnt;
   logic [DT_W-1:0] cnt_nxt;
   logic            pwm_q;
   logic            out_h_q;
   logic            out_l_q;
   logic            dt_active_q;
   logic            fault_flag_q;

   // PWM input register, state, counter and registered output decodes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_q        <= 1'b0;
         state        <= S_IDLE;
         cnt          <= '0;
         out_h_q      <= 1'b0;
         out_l_q      <= 1'b0;
         dt_active_q  <= 1'b0;
         fault_flag_q <= 1'b0;
      end else begin
         pwm_q        <= bus.pwm_in;
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         out_h_q      <= (state_nxt == S_HIGH);
         out_l_q      <= (state_nxt == S_LOW);
         dt_active_q  <= (state_nxt == S_DT_H) || (state_nxt == S_DT_L);
         fault_flag_q <= (state_nxt == S_FAULT);
      end
   end

   // Next state: fault beats enable, and enable beats the per-state rules
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (bus.fault) begin
         state_nxt = S_FAULT;
      end else if (state == S_FAULT) begin
         if (bus.fault_clr) state_nxt = S_IDLE;
      end else if (!bus.en) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (pwm_q) begin
                  state_nxt = S_DT_H;
                  cnt_nxt   = bus.dead_rise;
               end else begin
                  state_nxt = S_DT_L;
                  cnt_nxt   = bus.dead_fall;
               end
            end
            // A toggle during a dead time wins over expiry, so short pulses are swallowed
            S_DT_H: begin
               if (!pwm_q) begin
                  state_nxt = S_DT_L;
                  cnt_nxt   = bus.dead_fall;
               end else if (cnt == '0) begin
                  state_nxt = S_HIGH;
               end else begin
                  cnt_nxt = cnt - DT_W'(1);
               end
            end
            S_DT_L: begin
               if (pwm_q) begin
                  state_nxt = S_DT_H;
                  cnt_nxt   = bus.dead_rise;
               end else if (cnt == '0) begin
                  state_nxt = S_LOW;
               end else begin
                  cnt_nxt = cnt - DT_W'(1);
               end
            end
            S_HIGH: begin
               if (!pwm_q) begin
                  state_nxt = S_DT_L;
                  cnt_nxt   = bus.dead_fall;
               end
            end
            S_LOW: begin
               if (pwm_q) begin
                  state_nxt = S_DT_H;
                  cnt_nxt   = bus.dead_rise;
               end
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign bus.out_h      = out_h_q;
   assign bus.out_l      = out_l_q;
   assign bus.dt_active  = dt_active_q;
   assign bus.fault_flag = fault_flag_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: directed dead-time and fault scenarios, then a random run
// checked cycle by cycle against a gap-length model of the output stage.
module tb_pwm_deadtime;
   localparam int unsigned DT_W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pwm_deadtime_if #(.DT_W(DT_W)) bus ();

   pwm_deadtime #(.DT_W(DT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the stage is either off, latched in fault, or following one side with
   // m_left gap cycles still to go (-1 once that side conducts).
   bit m_q, m_fault, m_run, m_side;
   int m_left;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q = 1'b0; m_fault = 1'b0; m_run = 1'b0; m_side = 1'b0; m_left = -1;
      end else begin
         if (bus.fault) begin
            m_fault = 1'b1;
            m_run   = 1'b0;
         end else if (m_fault) begin
            if (bus.fault_clr) m_fault = 1'b0;
         end else if (!bus.en) begin
            m_run = 1'b0;
         end else if (!m_run || (m_q != m_side)) begin
            m_run  = 1'b1;
            m_side = m_q;
            m_left = m_q ? int'(bus.dead_rise) : int'(bus.dead_fall);
         end else if (m_left > 0) begin
            m_left--;
         end else begin
            m_left = -1;
         end
         m_q = bus.pwm_in;
      end
   end

   wire exp_h  = m_run && m_side && (m_left < 0);
   wire exp_l  = m_run && !m_side && (m_left < 0);
   wire exp_dt = m_run && (m_left >= 0);

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      check("cyc_out_h", bus.out_h, exp_h);
      check("cyc_out_l", bus.out_l, exp_l);
      check("cyc_dt_active", bus.dt_active, exp_dt);
      check("cyc_fault_flag", bus.fault_flag, m_fault);
      check("cyc_no_overlap", bus.out_h & bus.out_l, 1'b0);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Step until the wanted side conducts; lowcnt accumulates both-low cycles (-1 on timeout)
   task automatic run_until(input bit want_h, input int start_low, output int lowcnt, output bit saw_h);
      lowcnt = start_low;
      saw_h  = 1'b0;
      for (int i = 0; i < 600; i++) begin
         step();
         if ((want_h && bus.out_h) || (!want_h && bus.out_l)) return;
         if (bus.out_h) saw_h = 1'b1;
         if (!bus.out_h && !bus.out_l) lowcnt++;
      end
      lowcnt = -1;
   endtask

   // Drive a pwm edge toward lvl with dead time d and return the both-low gap length
   task automatic edge_gap(input bit lvl, input int d, output int n);
      bit s;
      if (lvl) bus.dead_rise = DT_W'(d);
      else     bus.dead_fall = DT_W'(d);
      bus.pwm_in = lvl;
      step();
      check("edge_hold_prev", lvl ? bus.out_l : bus.out_h, 1'b1);
      step();
      check("edge_deassert", bus.out_h | bus.out_l, 1'b0);
      run_until(lvl, 1, n, s);
   endtask

   int  gap;
   bit  saw;
   int  run_left;

   initial begin
      bus.en = 1'b0; bus.pwm_in = 1'b0; bus.fault = 1'b0; bus.fault_clr = 1'b0;
      bus.dead_rise = DT_W'(5); bus.dead_fall = DT_W'(3);
      step();
      step();
      check("rst_out_h", bus.out_h, 1'b0);
      check("rst_out_l", bus.out_l, 1'b0);
      check("rst_dt", bus.dt_active, 1'b0);
      check("rst_ff", bus.fault_flag, 1'b0);
      rst_n = 1'b1;
      step();

      // Start-up: pwm low, dead_fall 3 gives 4 dead-time cycles then out_l
      bus.en = 1'b1;
      step();
      check("start_dt", bus.dt_active, 1'b1);
      run_until(1'b0, 1, gap, saw);
      check_int("start_gap", gap, 4);
      check("start_out_l", bus.out_l, 1'b1);
      check("start_out_h", bus.out_h, 1'b0);
      check("model_pin_l", exp_l, 1'b1);

      // Rising gaps of 6 and 1 cycles, falling gap of 4
      edge_gap(1'b1, 5, gap);
      check_int("rise_gap_5", gap, 6);
      check("rise_out_h", bus.out_h, 1'b1);
      check("model_pin_h", exp_h, 1'b1);
      edge_gap(1'b0, 3, gap);
      check_int("fall_gap_3", gap, 4);
      edge_gap(1'b1, 0, gap);
      check_int("rise_gap_0", gap, 1);

      // Swallowed 3-cycle high pulse
      edge_gap(1'b0, 2, gap);
      check_int("fall_gap_2", gap, 3);
      bus.dead_rise = DT_W'(5);
      bus.pwm_in = 1'b1;
      step();
      step();
      step();
      bus.pwm_in = 1'b0;
      run_until(1'b0, 2, gap, saw);
      check_int("swallow_gap", gap, 6);
      check("swallow_no_h", saw, 1'b0);

      // dead_rise changed while the counter is at 4 only affects the next entry
      bus.dead_rise = DT_W'(6);
      bus.pwm_in = 1'b1;
      step();
      step();
      step();
      step();
      bus.dead_rise = DT_W'(10);
      run_until(1'b1, 3, gap, saw);
      check_int("chg_old_gap", gap, 7);
      edge_gap(1'b0, 2, gap);
      check_int("chg_fall_gap", gap, 3);
      edge_gap(1'b1, 10, gap);
      check_int("chg_new_gap", gap, 11);

      // Fault while HIGH, clear ignored while fault held, then restart sequence
      bus.fault = 1'b1;
      step();
      check("flt_out_h", bus.out_h, 1'b0);
      check("flt_flag", bus.fault_flag, 1'b1);
      bus.fault_clr = 1'b1;
      step();
      check("flt_clr_ignored", bus.fault_flag, 1'b1);
      bus.fault = 1'b0;
      bus.fault_clr = 1'b0;
      step();
      check("flt_latched", bus.fault_flag, 1'b1);
      bus.fault_clr = 1'b1;
      step();
      bus.fault_clr = 1'b0;
      check("flt_cleared", bus.fault_flag, 1'b0);
      check("flt_idle_dt", bus.dt_active, 1'b0);
      step();
      check("flt_reentry_dt", bus.dt_active, 1'b1);
      run_until(1'b1, 1, gap, saw);
      check_int("flt_reentry_gap", gap, 11);

      // en low during HIGH: both low at next edge
      bus.en = 1'b0;
      step();
      check("en_off_h", bus.out_h, 1'b0);
      check("en_off_l", bus.out_l, 1'b0);
      check("en_off_dt", bus.dt_active, 1'b0);

      // Asynchronous reset in the middle of a 200-cycle dead time
      bus.en = 1'b1;
      bus.dead_fall = DT_W'(200);
      bus.pwm_in = 1'b0;
      for (int i = 0; i < 8; i++) step();
      check("pre_rst_dt", bus.dt_active, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_dt", bus.dt_active, 1'b0);
      check("arst_h", bus.out_h, 1'b0);
      check("arst_l", bus.out_l, 1'b0);
      check("arst_ff", bus.fault_flag, 1'b0);
      bus.en = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_dt", bus.dt_active, 1'b0);
      check("post_rst_l", bus.out_l, 1'b0);

      // Random run checked every cycle by the compare process
      bus.en = 1'b1;
      bus.dead_rise = DT_W'(2);
      bus.dead_fall = DT_W'(2);
      run_left = 1;
      for (int c = 0; c < 10000; c++) begin
         if (run_left == 0) begin
            bus.pwm_in = ~bus.pwm_in;
            run_left = int'($urandom_range(1, 12));
         end
         run_left--;
         if ($urandom_range(0, 63) == 0) bus.dead_rise = DT_W'($urandom_range(0, 6));
         if ($urandom_range(0, 63) == 0) bus.dead_fall = DT_W'($urandom_range(0, 6));
         bus.fault     = ($urandom_range(0, 499) == 0);
         bus.fault_clr = ($urandom_range(0, 15) == 0);
         bus.en        = ($urandom_range(0, 299) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
